// File: rtl/interrupt_entry_sequencer.sv
// Interrupt entry sequencer: pulls a request from the interrupt controller, arbitrates it against
// the current PSW priority, pushes PC/LR/PSW, fetches the vector and hands the new context to the CPU.
module interrupt_entry_sequencer #(
    parameter logic [15:0] VEC_BASE = 16'hFFC0,
    parameter logic [15:0] LR_MAGIC = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pi,
    input  logic [7:0]  dev_code,
    input  logic [2:0]  dev_pri,
    output logic        int_read,
    input  logic        boundary,
    input  logic [15:0] psw_in,
    input  logic [15:0] pc_in,
    input  logic [15:0] lr_in,
    input  logic [15:0] sp_in,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        ctx_load,
    output logic [15:0] new_pc,
    output logic [15:0] new_psw,
    output logic [15:0] new_lr,
    output logic [15:0] new_sp,
    output logic [3:0]  state_dbg
);

    // Handshake: a memory request (mem_rd or mem_wr with mem_addr/mem_wdata) is held stable
    // until the cycle mem_ready=1 is sampled with it; that cycle completes the transfer.
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        READ      = 4'd1,
        ARB       = 4'd2,
        STACK_PC  = 4'd3,
        STACK_LR  = 4'd4,
        STACK_PSW = 4'd5,
        FETCH_PSW = 4'd6,
        FETCH_PC  = 4'd7,
        COMMIT    = 4'd8
    } state_t;

    state_t      state, state_next;
    logic [15:0] pc_snap, lr_snap, psw_snap, sp_reg;
    logic [2:0]  cur_idx, cur_pri;
    logic        use_def;
    logic        def_valid;
    logic [2:0]  def_idx, def_pri;
    logic [15:0] new_pc_r, new_psw_r;

    logic        take_def, take_new, defer;
    logic [15:0] sp_dec, vec_addr;
    logic [2:0]  unused_rdata_bits;

    assign sp_dec            = sp_reg - 16'd2;
    assign vec_addr          = VEC_BASE + {11'd0, cur_idx, 2'b00};
    assign unused_rdata_bits = mem_rdata[7:5];

    assign new_pc    = new_pc_r;
    assign new_psw   = new_psw_r;
    assign new_lr    = LR_MAGIC;
    assign new_sp    = sp_reg;
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        int_read   = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;
        busy       = 1'b0;
        ctx_load   = 1'b0;
        take_def   = 1'b0;
        take_new   = 1'b0;
        defer      = 1'b0;
        case (state)
            IDLE: begin
                if (def_valid && (def_pri > psw_in[7:5]) && psw_in[4] && boundary) begin
                    take_def   = 1'b1;
                    state_next = STACK_PC;
                end else if (!def_valid && pi && psw_in[4] && boundary) begin
                    state_next = READ;
                end
            end
            READ: begin
                int_read   = 1'b1;
                state_next = ARB;
            end
            ARB: begin
                // A zero device code means the request vanished: drop it without stacking.
                if (dev_code == 8'h00) begin
                    state_next = IDLE;
                end else if (dev_pri > psw_in[7:5]) begin
                    take_new   = 1'b1;
                    state_next = STACK_PC;
                end else begin
                    defer      = 1'b1;
                    state_next = IDLE;
                end
            end
            STACK_PC, STACK_LR, STACK_PSW: begin
                busy     = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = sp_dec;
                case (state)
                    STACK_PC: mem_wdata = pc_snap;
                    STACK_LR: mem_wdata = lr_snap;
                    default:  mem_wdata = psw_snap;
                endcase
                if (mem_ready) begin
                    case (state)
                        STACK_PC: state_next = STACK_LR;
                        STACK_LR: state_next = STACK_PSW;
                        default:  state_next = FETCH_PSW;
                    endcase
                end
            end
            FETCH_PSW: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = vec_addr;
                if (mem_ready) state_next = FETCH_PC;
            end
            FETCH_PC: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = vec_addr + 16'd2;
                if (mem_ready) state_next = COMMIT;
            end
            COMMIT: begin
                busy       = 1'b1;
                ctx_load   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc_snap   <= 16'h0000;
            lr_snap   <= 16'h0000;
            psw_snap  <= 16'h0000;
            sp_reg    <= 16'h0000;
            cur_idx   <= 3'd0;
            cur_pri   <= 3'd0;
            use_def   <= 1'b0;
            def_valid <= 1'b0;
            def_idx   <= 3'd0;
            def_pri   <= 3'd0;
            new_pc_r  <= 16'h0000;
            new_psw_r <= 16'h0000;
        end else begin
            state <= state_next;
            if (take_def || take_new) begin
                pc_snap  <= pc_in;
                lr_snap  <= lr_in;
                psw_snap <= psw_in;
                sp_reg   <= sp_in;
                use_def  <= take_def;
            end
            if (take_def) begin
                cur_idx <= def_idx;
                cur_pri <= def_pri;
            end
            if (take_new) begin
                cur_idx <= dev_code[4:2];
                cur_pri <= dev_pri;
            end
            if (defer) begin
                def_valid <= 1'b1;
                def_idx   <= dev_code[4:2];
                def_pri   <= dev_pri;
            end
            // SP pre-decrements only when a push completes; 16-bit wrap is intended.
            if (mem_wr && mem_ready) sp_reg <= sp_dec;
            if (state == FETCH_PSW && mem_ready)
                new_psw_r <= {mem_rdata[15:8], cur_pri, mem_rdata[4:0]};
            if (state == FETCH_PC && mem_ready) new_pc_r <= mem_rdata;
            if (state == COMMIT && use_def) def_valid <= 1'b0;
        end
    end

endmodule
